reset_sequencer: RTL and testbench

Generates the J1 core's reset from the MMCM lock status and the board reset button. It sits directly downstream of the clock-generation block and runs on that block's gated 80 MHz output clock. It holds the core in reset until the MMCM is locked and the button is released, then keeps reset asserted for a fixed hold time. It re-enters reset on lock loss or a debounced button press.

---
 rtl/j1sc_clk_pkg.sv | 19 +
 rtl/sync_debounce.sv | 51 +++++
 rtl/reset_sequencer.sv | 106 ++++++++++
 tb/tb_reset_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/j1sc_clk_pkg.sv
// rtl/j1sc_clk_pkg.sv - shared state enum and 80 MHz core-clock defaults for reset sequencing
package j1sc_clk_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } seq_state_e;

   // 10 ms debounce window at 80 MHz
   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 800000;
   localparam int DEFAULT_HOLD_CYCLES     = 1024;

   function automatic int width_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - button synchroniser and stable-level debouncer
module sync_debounce
   import j1sc_clk_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic btn_i,
   output logic btn_stable_o
);

   localparam int              DB_W    = width_min1(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   stable_q, stable_d;
   logic                   btn_s;

   assign btn_s        = sync_q[SYNC_STAGES-1];
   assign btn_stable_o = stable_q;

   // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], btn_i};
      stable_d = stable_q;
      db_cnt_d = '0;
      if (btn_s != stable_q) begin
         if (db_cnt_q == DB_LAST) begin
            stable_d = btn_s;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q   <= '0;
         db_cnt_q <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         db_cnt_q <= db_cnt_d;
         stable_q <= stable_d;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - J1 core reset generation from MMCM lock and board reset button
module reset_sequencer
   import j1sc_clk_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       isLocked,
   input  logic       extResetBtn,
   output logic       coreReset,
   output logic       ready,
   output logic [7:0] lockLossCount
);

   localparam int                HOLD_W    = width_min1(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
   logic                   lock_s;
   logic                   btn_press;
   logic                   btn_stable;
   seq_state_e             state_q, state_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic [7:0]             loss_cnt_q, loss_cnt_d;
   logic                   core_reset_q, core_reset_d;
   logic                   ready_q, ready_d;

   assign lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], isLocked};
   assign lock_s      = lock_sync_q[SYNC_STAGES-1];
   assign btn_press   = BTN_ACTIVE_LOW ? ~extResetBtn : extResetBtn;

   sync_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk_i        (clk),
      .reset_i      (reset),
      .btn_i        (btn_press),
      .btn_stable_o (btn_stable)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_sync_q  <= '0;
         state_q      <= WAIT_LOCK;
         hold_cnt_q   <= '0;
         loss_cnt_q   <= '0;
         core_reset_q <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         lock_sync_q  <= lock_sync_d;
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         loss_cnt_q   <= loss_cnt_d;
         core_reset_q <= core_reset_d;
         ready_q      <= ready_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      loss_cnt_d = loss_cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            if (lock_s && !btn_stable) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         HOLD: begin
            if (!lock_s || btn_stable) begin
               state_d = WAIT_LOCK;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         RUN: begin
            // A simultaneous lock loss and button press counts once
            if (!lock_s || btn_stable) begin
               state_d = WAIT_LOCK;
               if (!lock_s && loss_cnt_q != 8'hFF) begin
                  loss_cnt_d = loss_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   always_comb begin
      core_reset_d = (state_d != RUN);
      ready_d      = (state_d == RUN);
   end

   assign coreReset     = core_reset_q;
   assign ready         = ready_q;
   assign lockLossCount = loss_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;

   localparam int S = 2;
   localparam int H = 8;
   localparam int D = 16;

   logic       clk;
   logic       reset;
   logic       isLocked;
   logic       extResetBtn;
   logic       coreReset;
   logic       ready;
   logic [7:0] lockLossCount;

   int checks = 0;
   int errors = 0;

   reset_sequencer #(
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .isLocked      (isLocked),
      .extResetBtn   (extResetBtn),
      .coreReset     (coreReset),
      .ready         (ready),
      .lockLossCount (lockLossCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: input delay lines, a run length of disagreeing button samples,
   // and a streak of edges on which release conditions held.
   bit m_lock [S];
   bit m_btn  [S];
   bit m_stable;
   int m_dis;
   int m_streak;
   bit m_run;
   int m_cnt;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      bit ls;
      bit bs;
      if (reset) begin
         for (int i = 0; i < S; i++) begin
            m_lock[i] = 1'b0;
            m_btn[i]  = 1'b0;
         end
         m_stable = 1'b0;
         m_dis    = 0;
         m_streak = 0;
         m_run    = 1'b0;
         m_cnt    = 0;
         m_valid  = 1'b1;
      end else begin
         ls = m_lock[S-1];
         bs = m_btn[S-1];
         if (m_run && !ls && m_cnt < 255) m_cnt++;
         if (ls && !m_stable) m_streak++;
         else m_streak = 0;
         m_run = (m_streak > H);
         if (bs != m_stable) begin
            m_dis++;
            if (m_dis == D) begin
               m_stable = bs;
               m_dis    = 0;
            end
         end else begin
            m_dis = 0;
         end
         for (int i = S - 1; i > 0; i--) begin
            m_lock[i] = m_lock[i-1];
            m_btn[i]  = m_btn[i-1];
         end
         m_lock[0] = isLocked;
         m_btn[0]  = ~extResetBtn;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_coreReset", int'(coreReset), int'(!m_run));
         check("model_ready", int'(ready), int'(m_run));
         check("model_count", int'(lockLossCount), m_cnt);
      end
   end

   initial begin
      reset       = 1'b1;
      isLocked    = 1'b1;
      extResetBtn = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_coreReset", int'(coreReset), 1);
      check("rst_ready", int'(ready), 0);
      check("rst_count", int'(lockLossCount), 0);

      // power-up release: RUN after edge 10
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("release_e9_coreReset", int'(coreReset), 1);
      @(negedge clk);
      check("release_e10_coreReset", int'(coreReset), 0);
      check("release_e10_ready", int'(ready), 1);
      check("release_e10_count", int'(lockLossCount), 0);

      // one-cycle lock loss in RUN
      isLocked = 1'b0;
      @(negedge clk);
      isLocked = 1'b1;
      @(negedge clk);
      check("loss_e1_coreReset", int'(coreReset), 0);
      @(negedge clk);
      check("loss_e2_coreReset", int'(coreReset), 1);
      check("loss_e2_count", int'(lockLossCount), 1);
      repeat (8) @(negedge clk);
      check("relock_e9_coreReset", int'(coreReset), 1);
      @(negedge clk);
      check("relock_e10_coreReset", int'(coreReset), 0);

      // held button press
      extResetBtn = 1'b0;
      repeat (18) @(negedge clk);
      check("press_e17_coreReset", int'(coreReset), 0);
      @(negedge clk);
      check("press_e18_coreReset", int'(coreReset), 1);
      @(negedge clk);
      extResetBtn = 1'b1;
      repeat (26) @(negedge clk);
      check("unpress_e25_coreReset", int'(coreReset), 1);
      @(negedge clk);
      check("unpress_e26_coreReset", int'(coreReset), 0);

      // 10-cycle bounce is ignored
      extResetBtn = 1'b0;
      repeat (10) @(negedge clk);
      extResetBtn = 1'b1;
      repeat (30) @(negedge clk);
      check("bounce_coreReset", int'(coreReset), 0);
      check("bounce_ready", int'(ready), 1);

      // lock glitch at holdCnt=5 restarts the hold
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      isLocked = 1'b0;
      @(negedge clk);
      isLocked = 1'b1;
      repeat (10) @(negedge clk);
      check("hold_glitch_e16_coreReset", int'(coreReset), 1);
      @(negedge clk);
      check("hold_glitch_e17_coreReset", int'(coreReset), 0);
      check("hold_glitch_count", int'(lockLossCount), 0);

      // saturation of the lock-loss counter
      repeat (300) begin
         isLocked = 1'b0;
         @(negedge clk);
         isLocked = 1'b1;
         repeat (12) @(negedge clk);
      end
      check("sat_count", int'(lockLossCount), 255);
      check("sat_ready", int'(ready), 1);

      // reset in RUN acts on the next edge
      reset = 1'b1;
      @(negedge clk);
      check("rst_run_coreReset", int'(coreReset), 1);
      check("rst_run_ready", int'(ready), 0);
      check("rst_run_count", int'(lockLossCount), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
